// File: rtl/pico_frame_rx_if.sv
// Serial frame receiver bus: SPI-side inputs plus register-write and status outputs.
interface pico_frame_rx_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned ADDR_W = 7
);
    logic              sclk;
    logic              serial_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              frame_active;
    logic              timeout_pulse;
    logic              frame_err;

    modport master (
        output sclk, serial_in,
        input  wr_en, wr_addr, wr_data, rd_addr, frame_active, timeout_pulse, frame_err
    );

    modport slave (
        input  sclk, serial_in,
        output wr_en, wr_addr, wr_data, rd_addr, frame_active, timeout_pulse, frame_err
    );
endinterface

// File: rtl/pico_frame_rx.sv
// SPI-style frame receiver: command word selects a register pointer, following words
// are written (auto-incrementing) or skipped; frames end on an idle timeout.
module pico_frame_rx #(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned NUM_REGS    = 2 ** ADDR_W,
    parameter int unsigned IDLE_CYCLES = 8
) (
    input logic             iclk,
    input logic             rst,
    pico_frame_rx_if.slave  bus
);
    localparam int unsigned CntW  = $clog2(WORD_W);
    localparam int unsigned IdleW = $clog2(IDLE_CYCLES);
    localparam logic [ADDR_W:0]   NumRegsW = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LastReg  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {StIdle, StCmd, StWrite, StRead, StSkip} state_e;

    state_e            state_q, state_d;
    logic              sclk_m_q, sclk_s_q, sclk_d_q, sin_m_q, sin_s_q;
    // The shifter keeps only WORD_W-1 bits; the oldest bit leaves as the word completes.
    logic [WORD_W-2:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, rd_addr_q, rd_addr_d;
    logic              wr_pend_q, wr_pend_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              tmo_q, tmo_d, ferr_q, ferr_d;

    logic              sclk_rise, word_done, timeout;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] cmd_addr, ptr_next;

    // State register
    always_ff @(posedge iclk) begin
        if (rst) begin
            // Synchronizers reset high so a held-high sclk gives no edge on release.
            sclk_m_q   <= 1'b1;
            sclk_s_q   <= 1'b1;
            sclk_d_q   <= 1'b1;
            sin_m_q    <= 1'b1;
            sin_s_q    <= 1'b1;
            state_q    <= StIdle;
            shreg_q    <= '0;
            word_q     <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            ptr_q      <= '0;
            rd_addr_q  <= '0;
            wr_pend_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            tmo_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sclk_m_q   <= bus.sclk;
            sclk_s_q   <= sclk_m_q;
            sclk_d_q   <= sclk_s_q;
            sin_m_q    <= bus.serial_in;
            sin_s_q    <= sin_m_q;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            ptr_q      <= ptr_d;
            rd_addr_q  <= rd_addr_d;
            wr_pend_q  <= wr_pend_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            tmo_q      <= tmo_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        sclk_rise = sclk_s_q & ~sclk_d_q;
        word      = {shreg_q, sin_s_q};
        word_done = sclk_rise && (bit_cnt_q == CntW'(WORD_W - 1));
        timeout   = (state_q != StIdle) && !sclk_rise && (idle_cnt_q == IdleW'(IDLE_CYCLES - 1));
        cmd_addr  = word[ADDR_W-1:0];
        ptr_next  = (ptr_q == LastReg) ? '0 : ptr_q + 1'b1;

        state_d    = state_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        ptr_d      = ptr_q;
        rd_addr_d  = rd_addr_q;
        wr_pend_d  = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        tmo_d      = 1'b0;
        ferr_d     = 1'b0;

        // A write word completed last cycle: strobe it out and advance the pointer.
        if (wr_pend_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = word_q;
            ptr_d     = ptr_next;
            rd_addr_d = ptr_next;
        end

        if (sclk_rise) begin
            shreg_d    = word[WORD_W-2:0];
            bit_cnt_d  = word_done ? '0 : bit_cnt_q + 1'b1;
            idle_cnt_d = '0;
            if (state_q == StIdle) state_d = StCmd;
            if (word_done) begin
                case (state_q)
                    StCmd: begin
                        if ({1'b0, cmd_addr} >= NumRegsW) begin
                            state_d = StSkip;
                        end else begin
                            ptr_d     = cmd_addr;
                            rd_addr_d = cmd_addr;
                            state_d   = word[WORD_W-1] ? StWrite : StRead;
                        end
                    end
                    StWrite: begin
                        wr_pend_d = 1'b1;
                        word_d    = word;
                    end
                    StRead: begin
                        ptr_d     = ptr_next;
                        rd_addr_d = ptr_next;
                    end
                    default: ;
                endcase
            end
        end else if (timeout) begin
            state_d    = StIdle;
            bit_cnt_d  = '0;
            shreg_d    = '0;
            idle_cnt_d = '0;
            tmo_d      = 1'b1;
            ferr_d     = (bit_cnt_q != '0) || (state_q == StSkip);
        end else if (state_q != StIdle) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = '0;
        end
    end

    // Outputs
    always_comb begin
        bus.wr_en         = wr_en_q;
        bus.wr_addr       = wr_addr_q;
        bus.wr_data       = wr_data_q;
        bus.rd_addr       = rd_addr_q;
        bus.frame_active  = (state_q != StIdle);
        bus.timeout_pulse = tmo_q;
        bus.frame_err     = ferr_q;
    end
endmodule

// File: tb/tb_pico_frame_rx.sv
// Scoreboard bench for pico_frame_rx across four parameter sets.
module tb_pico_frame_rx;
    localparam int Half = 3;
    localparam int NDut = 4;

    logic iclk = 1'b0;
    logic rst  = 1'b1;
    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_rise = 0;
    int nz_cnt = 0;
    int orphan_cnt = 0;
    int tmo_cnt [NDut];
    logic ferr_last [NDut];

    logic sclk_v [NDut];
    logic sin_v [NDut];
    logic wr_en_v [NDut];
    logic [31:0] wr_addr_v [NDut];
    logic [31:0] wr_data_v [NDut];
    logic [31:0] rd_addr_v [NDut];
    logic fa_v [NDut];
    logic tmo_v [NDut];
    logic ferr_v [NDut];

    typedef struct {
        int dut;
        int addr;
        int data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    pico_frame_rx_if #(.WORD_W(8),  .ADDR_W(7)) if0 ();
    pico_frame_rx_if #(.WORD_W(8),  .ADDR_W(2)) if1 ();
    pico_frame_rx_if #(.WORD_W(8),  .ADDR_W(7)) if2 ();
    pico_frame_rx_if #(.WORD_W(12), .ADDR_W(7)) if3 ();

    pico_frame_rx #(.WORD_W(8), .ADDR_W(7), .NUM_REGS(128), .IDLE_CYCLES(8)) u_dut0 (
        .iclk(iclk), .rst(rst), .bus(if0));
    pico_frame_rx #(.WORD_W(8), .ADDR_W(2), .NUM_REGS(4), .IDLE_CYCLES(8)) u_dut1 (
        .iclk(iclk), .rst(rst), .bus(if1));
    pico_frame_rx #(.WORD_W(8), .ADDR_W(7), .NUM_REGS(4), .IDLE_CYCLES(8)) u_dut2 (
        .iclk(iclk), .rst(rst), .bus(if2));
    pico_frame_rx #(.WORD_W(12), .ADDR_W(7), .NUM_REGS(128), .IDLE_CYCLES(8)) u_dut3 (
        .iclk(iclk), .rst(rst), .bus(if3));

    assign if0.sclk = sclk_v[0];
    assign if1.sclk = sclk_v[1];
    assign if2.sclk = sclk_v[2];
    assign if3.sclk = sclk_v[3];
    assign if0.serial_in = sin_v[0];
    assign if1.serial_in = sin_v[1];
    assign if2.serial_in = sin_v[2];
    assign if3.serial_in = sin_v[3];

    assign wr_en_v[0] = if0.wr_en;
    assign wr_en_v[1] = if1.wr_en;
    assign wr_en_v[2] = if2.wr_en;
    assign wr_en_v[3] = if3.wr_en;
    assign wr_addr_v[0] = 32'(if0.wr_addr);
    assign wr_addr_v[1] = 32'(if1.wr_addr);
    assign wr_addr_v[2] = 32'(if2.wr_addr);
    assign wr_addr_v[3] = 32'(if3.wr_addr);
    assign wr_data_v[0] = 32'(if0.wr_data);
    assign wr_data_v[1] = 32'(if1.wr_data);
    assign wr_data_v[2] = 32'(if2.wr_data);
    assign wr_data_v[3] = 32'(if3.wr_data);
    assign rd_addr_v[0] = 32'(if0.rd_addr);
    assign rd_addr_v[1] = 32'(if1.rd_addr);
    assign rd_addr_v[2] = 32'(if2.rd_addr);
    assign rd_addr_v[3] = 32'(if3.rd_addr);
    assign fa_v[0] = if0.frame_active;
    assign fa_v[1] = if1.frame_active;
    assign fa_v[2] = if2.frame_active;
    assign fa_v[3] = if3.frame_active;
    assign tmo_v[0] = if0.timeout_pulse;
    assign tmo_v[1] = if1.timeout_pulse;
    assign tmo_v[2] = if2.timeout_pulse;
    assign tmo_v[3] = if3.timeout_pulse;
    assign ferr_v[0] = if0.frame_err;
    assign ferr_v[1] = if1.frame_err;
    assign ferr_v[2] = if2.frame_err;
    assign ferr_v[3] = if3.frame_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input int d, input int a, input int v);
        wr_t e;
        e.dut  = d;
        e.addr = a;
        e.data = v;
        exp_q.push_back(e);
    endtask

    // Each bit: low phase with data set, then rising sclk held for Half cycles.
    task automatic send_bits(input int sel, input logic [31:0] w, input int n, input int low);
        for (int i = n - 1; i >= 0; i--) begin
            sclk_v[sel] = 1'b0;
            sin_v[sel]  = w[i];
            repeat (low) @(negedge iclk);
            sclk_v[sel] = 1'b1;
            last_rise   = cyc;
            repeat (Half) @(negedge iclk);
        end
    endtask

    task automatic go_idle(input int sel, input int n);
        sclk_v[sel] = 1'b0;
        repeat (n) @(negedge iclk);
    endtask

    // Scoreboard and protocol monitor
    always @(negedge iclk) begin
        for (int d = 0; d < NDut; d++) begin
            if (wr_en_v[d]) begin
                if (exp_q.size() == 0) begin
                    check_val("wr_unexpected", {31'b0, wr_en_v[d]}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("wr_dut", d, mon_e.dut);
                    check_val("wr_addr", wr_addr_v[d], mon_e.addr);
                    check_val("wr_data", wr_data_v[d], mon_e.data);
                    check_val("wr_latency", cyc - last_rise, 4);
                end
            end else if ((wr_addr_v[d] | wr_data_v[d]) != 32'h0) begin
                nz_cnt++;
            end
            if (tmo_v[d]) begin
                tmo_cnt[d]++;
                ferr_last[d] = ferr_v[d];
            end else if (ferr_v[d]) begin
                orphan_cnt++;
            end
        end
    end

    initial begin
        int tmo_before;
        for (int d = 0; d < NDut; d++) begin
            sclk_v[d] = 1'b0;
            sin_v[d]  = 1'b0;
            tmo_cnt[d] = 0;
            ferr_last[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (4) @(negedge iclk);
        check_val("rst_wr_en", {31'b0, wr_en_v[0]}, 0);
        check_val("rst_rd_addr", rd_addr_v[0], 0);
        check_val("rst_active", {31'b0, fa_v[0]}, 0);
        check_val("rst_tmo", {31'b0, tmo_v[0]}, 0);
        rst = 1'b0;
        repeat (4) @(negedge iclk);
        check_val("idle_active", {31'b0, fa_v[0]}, 0);

        // Write frame with auto-increment
        push_wr(0, 5, 'hA5);
        push_wr(0, 6, 'h3C);
        send_bits(0, 'h85, 8, Half);
        check_val("t1_active", {31'b0, fa_v[0]}, 1);
        check_val("t1_rd0", rd_addr_v[0], 5);
        send_bits(0, 'hA5, 8, Half);
        @(negedge iclk);
        check_val("t1_rd1", rd_addr_v[0], 6);
        send_bits(0, 'h3C, 8, Half);
        @(negedge iclk);
        check_val("t1_rd2", rd_addr_v[0], 7);
        go_idle(0, 30);
        check_val("t1_tmo", tmo_cnt[0], 1);
        check_val("t1_ferr", {31'b0, ferr_last[0]}, 0);
        check_val("t1_inactive", {31'b0, fa_v[0]}, 0);
        check_val("t1_rd_hold", rd_addr_v[0], 7);
        check_val("t1_drain", exp_q.size(), 0);

        // Read frame; 8-cycle bit spacing puts every edge on the timeout boundary
        send_bits(0, 'h10, 8, 5);
        check_val("t2_rd0", rd_addr_v[0], 'h10);
        send_bits(0, 'h00, 8, 5);
        check_val("t2_rd1", rd_addr_v[0], 'h11);
        send_bits(0, 'h00, 8, 5);
        check_val("t2_rd2", rd_addr_v[0], 'h12);
        go_idle(0, 30);
        check_val("t2_tmo", tmo_cnt[0], 2);
        check_val("t2_ferr", {31'b0, ferr_last[0]}, 0);

        // Pointer wrap with NUM_REGS=4, ADDR_W=2
        push_wr(1, 3, 'h11);
        push_wr(1, 0, 'h22);
        send_bits(1, 'h83, 8, Half);
        check_val("t3_rd0", rd_addr_v[1], 3);
        send_bits(1, 'h11, 8, Half);
        @(negedge iclk);
        check_val("t3_rd1", rd_addr_v[1], 0);
        send_bits(1, 'h22, 8, Half);
        @(negedge iclk);
        check_val("t3_rd2", rd_addr_v[1], 1);
        go_idle(1, 30);
        check_val("t3_drain", exp_q.size(), 0);
        check_val("t3_tmo", tmo_cnt[1], 1);

        // Out-of-range command goes to SKIP
        send_bits(2, 'h86, 8, Half);
        send_bits(2, 'h55, 8, Half);
        go_idle(2, 30);
        check_val("t4_tmo", tmo_cnt[2], 1);
        check_val("t4_ferr", {31'b0, ferr_last[2]}, 1);
        check_val("t4_rd_addr", rd_addr_v[2], 0);

        // Partial word, then clean restart
        send_bits(0, 'h81, 8, Half);
        send_bits(0, 'h5, 3, Half);
        go_idle(0, 30);
        check_val("t5_tmo", tmo_cnt[0], 3);
        check_val("t5_ferr", {31'b0, ferr_last[0]}, 1);
        push_wr(0, 2, 'h77);
        send_bits(0, 'h82, 8, Half);
        send_bits(0, 'h77, 8, Half);
        go_idle(0, 30);
        check_val("t5_tmo2", tmo_cnt[0], 4);
        check_val("t5_ferr2", {31'b0, ferr_last[0]}, 0);
        check_val("t5_drain", exp_q.size(), 0);
        check_val("t5_rd", rd_addr_v[0], 3);

        // Reset mid-data-word, sclk held high through release
        tmo_before = tmo_cnt[0];
        send_bits(0, 'h83, 8, Half);
        send_bits(0, 'hA, 4, Half);
        rst = 1'b1;
        repeat (2) @(negedge iclk);
        check_val("t6_wr_en", {31'b0, wr_en_v[0]}, 0);
        check_val("t6_rd_addr", rd_addr_v[0], 0);
        check_val("t6_active", {31'b0, fa_v[0]}, 0);
        check_val("t6_ferr", {31'b0, ferr_v[0]}, 0);
        rst = 1'b0;
        repeat (20) @(negedge iclk);
        check_val("t6_no_edge", {31'b0, fa_v[0]}, 0);
        check_val("t6_no_tmo", tmo_cnt[0], tmo_before);
        go_idle(0, 5);

        // 12-bit words
        push_wr(3, 5, 'hABC);
        send_bits(3, 'h805, 12, Half);
        check_val("t7_rd0", rd_addr_v[3], 5);
        send_bits(3, 'hABC, 12, Half);
        go_idle(3, 30);
        check_val("t7_rd1", rd_addr_v[3], 6);
        check_val("t7_drain", exp_q.size(), 0);
        check_val("t7_tmo", tmo_cnt[3], 1);

        check_val("idle_outputs_zero", nz_cnt, 0);
        check_val("ferr_without_tmo", orphan_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pico_frame_rx.md
PICO_FRAME_RX -- requirements
Module: pico_frame_rx

Interface
REQ-001 Parameter WORD_W, default 8: serial word width in bits, legal range 4..16.
REQ-002 Parameter ADDR_W, default 7: register address width, legal range 1..WORD_W-1.
REQ-003 Parameter NUM_REGS, default 2**ADDR_W: number of valid register addresses, legal range 1..2**ADDR_W.
REQ-004 Parameter IDLE_CYCLES, default 8: iclk cycles with no sclk edge that end a frame, minimum 2.
REQ-005 iclk  in  1: single internal clock; all state is clocked on its rising edge.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 sclk  in  1: asynchronous SPI clock; data is captured on its rising edge.
REQ-008 serial_in  in  1: asynchronous serial data, MSB first.
REQ-009 wr_en  out  1: one-cycle write strobe.
REQ-010 wr_addr  out  ADDR_W: write address, valid while wr_en=1.
REQ-011 wr_data  out  WORD_W: write data, valid while wr_en=1.
REQ-012 rd_addr  out  ADDR_W: POCI mux select.
REQ-013 frame_active  out  1: high whenever state is not IDLE.
REQ-014 timeout_pulse  out  1: one-cycle pulse when a frame ends on idle timeout.
REQ-015 frame_err  out  1: one-cycle pulse, coincident with timeout_pulse, when the frame ended mid-word or was in SKIP.

Function
REQ-016 sclk and serial_in SHALL each pass through a 2-flop synchronizer; sclk_d SHALL hold the previous synchronized sclk; edge = sclk_s & ~sclk_d.
REQ-017 On each edge: shreg <= {shreg[WORD_W-2:0], serial_in_s}; bit_cnt increments; at bit_cnt==WORD_W-1 the word completes, word = {shreg[WORD_W-2:0], serial_in_s}, and bit_cnt wraps to 0.
REQ-018 States SHALL be IDLE, CMD, WRITE, READ and SKIP.
REQ-019 IDLE -> CMD on the first edge; that edge SHALL also shift in a bit.
REQ-020 On word completion in CMD: if word[ADDR_W-1:0] >= NUM_REGS -> SKIP; else ptr <= word[ADDR_W-1:0], rd_addr <= word[ADDR_W-1:0], then -> WRITE if word[WORD_W-1]=1, else -> READ.
REQ-021 On word completion in WRITE, the next cycle SHALL have wr_en=1, wr_addr=ptr (pre-increment) and wr_data=word; ptr and rd_addr SHALL then take ptr+1.
REQ-022 On word completion in READ: ptr and rd_addr <= ptr+1; wr_en stays 0.
REQ-023 ptr increment SHALL wrap from NUM_REGS-1 to 0.
REQ-024 In SKIP, bits are shifted but ignored; no wr_en is issued, and ptr and rd_addr are unchanged.
REQ-025 Latency: wr_en SHALL assert on the 3rd iclk rising edge after the edge at which the sclk pin is first sampled high.
REQ-026 wr_en, wr_addr and wr_data SHALL be 0 in every cycle except the strobe cycle.
REQ-027 idle_cnt SHALL clear on every edge and otherwise increment while state is not IDLE; in IDLE it SHALL hold 0.
REQ-028 When idle_cnt reaches IDLE_CYCLES-1 with no edge in that cycle, the next cycle SHALL have: state=IDLE, bit_cnt=0, shreg=0, timeout_pulse=1 and frame_err = (bit_cnt!=0 or state==SKIP).
REQ-029 A simultaneous edge and timeout SHALL resolve as edge wins: the timeout is suppressed and idle_cnt clears.
REQ-030 rd_addr SHALL hold its value across timeout into IDLE.
REQ-031 Input timing constraint: each sclk high and low phase SHALL be at least 3 iclk cycles; edge detection is guaranteed only under this constraint.

Reset
REQ-032 While rst=1 at an iclk edge: state=IDLE, and shreg, bit_cnt, idle_cnt, ptr and every output SHALL be 0.
REQ-033 Synchronizer flops and sclk_d SHALL reset to 1, so sclk held high through reset release produces no edge.
REQ-034 rst mid-frame SHALL abort the frame with no wr_en, timeout_pulse or frame_err.

Verification
REQ-035 Defaults; frame 0x85, 0xA5, 0x3C, then idle -> wr_en at addr 5 data 0xA5, then addr 6 data 0x3C; rd_addr 5, 6, 7; one timeout_pulse; frame_err=0.
REQ-036 Read frame 0x10, 0x00, 0x00 -> no wr_en; rd_addr 0x10, 0x11, 0x12.
REQ-037 NUM_REGS=4, ADDR_W=2: frame 0x83, 0x11, 0x22 -> writes addr 3 data 0x11, then addr 0 data 0x22 (wrap).
REQ-038 NUM_REGS=4: cmd 0x86 -> SKIP, no writes; at timeout, frame_err=1 and timeout_pulse=1.
REQ-039 Frame 0x81 followed by 3 bits, then idle -> frame_err=1; next frame 0x82, 0x77 -> write addr 2 data 0x77, showing clean restart.
REQ-040 rst pulsed after 4 bits of a data word -> no strobe, all outputs 0; WORD_W=12 variant: cmd 0x805, data 0xABC -> write addr 5 data 0xABC.
